pipe_stage_skid_reg: RTL and testbench
======================================

Name: pipe_stage_skid_reg

Overview:
Parametrised elastic pipeline register, the successor to the fixed-width inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries one control bundle and one data bundle per entry, uses a valid/ready handshake, and holds entries in a two-entry skid buffer so back-pressure does not need a combinational ready path. Control bits are forced inert on bubbles. Flush squashes every in-flight entry.

Parameters:
DATA_W, 96, width of the data bundle (result, mem data, pc+4, imm, etc. concatenated)
CTRL_W, 8, width of the control bundle (reg_write, mem_read, mem_to_reg, etc.)
ZERO_DATA_ON_BUBBLE, 1, 1 = out_data reads 0 while out_valid=0; 0 = out_data holds its last value

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous squash of all held entries
in_valid  input  1  upstream entry is valid
in_ready  output  1  stage can accept an entry; registered
in_ctrl  input  CTRL_W  upstream control bundle
in_data  input  DATA_W  upstream data bundle
out_valid  output  1  out_ctrl/out_data hold a valid entry
out_ready  input  1  downstream accepts the entry
out_ctrl  output  CTRL_W  control bundle; all-zero whenever out_valid=0
out_data  output  DATA_W  data bundle
occupancy  output  2  number of held entries (0..2)

Behaviour:
- Interface: one clock domain (clk). reset is synchronous and active-high. All state updates on the rising edge of clk.
- Storage: a main entry that drives the outputs and a skid entry. Each entry has a valid bit, ctrl and data.
- Accept: the upstream transfer fires when in_valid && in_ready. The downstream transfer fires when out_valid && out_ready.
- States: EMPTY (occ 0), ONE (occ 1), FULL (occ 2).
- EMPTY + accept -> ONE. Entry goes to main. out_valid=1 the next cycle, so latency is 1 cycle.
- ONE + accept + drain -> ONE. Main is reloaded with the incoming entry.
- ONE + accept, no drain -> FULL. Incoming entry goes to skid.
- ONE + drain, no accept -> EMPTY.
- FULL + drain -> ONE. Skid moves to main. No accept is possible in FULL.
- No event -> state and contents hold.
- Ordering: strictly FIFO. No entry is duplicated or dropped except by flush or reset.
- in_ready = !(state==FULL), taken from a register. There is no combinational path from out_ready or in_valid to in_ready.
- out_valid = main valid. out_ctrl = main ctrl when out_valid, else 0.
- out_data: main data when out_valid. Otherwise 0 if ZERO_DATA_ON_BUBBLE=1, else the last loaded value.
- flush: next state is EMPTY, occupancy 0, in_ready=1, out_valid=0, out_ctrl=0. An input accepted in the same cycle as flush is discarded. A drain in the flush cycle still counts as delivered.
- reset: same end state as flush. All ctrl/data registers are cleared to 0. reset has priority over flush and over any handshake.
- Reset values: in_ready=1, out_valid=0, out_ctrl=0, out_data=0, occupancy=0.
- Reset mid-operation: held entries are lost. The first accept after reset deasserts behaves as from EMPTY.
- in_ctrl/in_data are sampled only on an accepted transfer. in_valid=0 with arbitrary data has no effect.
- Widths pass through unchanged. No arithmetic is performed on payload.

Test Plan:
- Reset then single pass: reset 2 cycles. Present in_valid=1, ctrl=8'h05, data=96'hA1 for 1 cycle with out_ready=1 -> next cycle out_valid=1, out_ctrl=05, out_data=A1. The cycle after, out_valid=0, out_ctrl=0, out_data=0. occupancy goes 1 then 0.
- Back-pressure/skid: out_ready=0. Send A1 then A2 on consecutive cycles -> occupancy=2 and in_ready=0 in the following cycle. Raise out_ready -> A1 appears, then A2, then out_valid=0. in_ready returns to 1 one cycle after the first drain.
- Streaming: in_valid=1 and out_ready=1 continuously with data 1..16 -> outputs 1..16 in order, one per cycle. in_ready stays 1 and occupancy stays 1 in steady state.
- Flush: hold 2 entries (B1, B2). Assert flush together with in_valid=1, data B3 -> next cycle occupancy=0, out_valid=0, out_ctrl=0, in_ready=1. B1, B2 and B3 never appear at the output.
- Reset vs flush: in FULL, assert reset and flush simultaneously -> reset values next cycle. Then send C1 -> C1 output after 1 cycle.
- ZERO_DATA_ON_BUBBLE=0 instance: send D1 and drain it -> after the drain out_valid=0, out_ctrl=0, out_data stays D1.

Source files
------------

// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg
//   Elastic inter-stage pipeline register with a two-entry skid buffer.
//   Carries one control bundle and one data bundle per entry over a
//   valid/ready handshake. in_ready is registered, so back-pressure never
//   forms a combinational path from out_ready to in_ready. Control bits
//   read as zero on bubbles; flush squashes every held entry.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset (priority over flush/handshake)
//   flush      synchronous squash of all held entries
//   in_valid   upstream entry valid
//   in_ready   stage can accept an entry (registered)
//   in_ctrl    upstream control bundle [CTRL_W]
//   in_data    upstream data bundle [DATA_W]
//   out_valid  out_ctrl/out_data hold a valid entry
//   out_ready  downstream accepts the entry
//   out_ctrl   control bundle, zero whenever out_valid=0
//   out_data   data bundle (zero or last loaded on bubbles, per ZERO_DATA_ON_BUBBLE)
//   occupancy  number of held entries (0..2)
module pipe_stage_skid_reg #(
  parameter int unsigned DATA_W              = 96,
  parameter int unsigned CTRL_W              = 8,
  parameter bit          ZERO_DATA_ON_BUBBLE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // Encoding equals the number of held entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              up_fire, dn_fire;
  logic              main_ld, main_from_skid, skid_ld;

  // Main entry is valid in ONE and FULL; skid entry only in FULL.
  assign out_valid = (state != EMPTY);
  assign occupancy = state;
  assign up_fire   = in_valid && in_ready;
  assign dn_fire   = out_valid && out_ready;

  always_comb begin
    state_n        = state;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    unique case (state)
      EMPTY: begin
        if (up_fire) begin
          state_n = ONE;
          main_ld = 1'b1;
        end
      end
      ONE: begin
        if (up_fire && dn_fire) begin
          main_ld = 1'b1;
        end else if (up_fire) begin
          state_n = FULL;
          skid_ld = 1'b1;
        end else if (dn_fire) begin
          state_n = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only a drain can occur.
        if (dn_fire) begin
          state_n        = ONE;
          main_from_skid = 1'b1;
        end
      end
      default: state_n = EMPTY;
    endcase
    // Flush discards a same-cycle accept; a same-cycle drain already left.
    if (flush) begin
      state_n        = EMPTY;
      main_ld        = 1'b0;
      main_from_skid = 1'b0;
      skid_ld        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      state    <= state_n;
      in_ready <= (state_n != FULL);
      if (main_ld) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (main_from_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (skid_ld) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end

  assign out_ctrl = out_valid ? main_ctrl : '0;
  assign out_data = (out_valid || !ZERO_DATA_ON_BUBBLE) ? main_data : '0;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
module tb_pipe_stage_skid_reg;
  localparam int unsigned DW = 96;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  logic          z_flush, z_in_valid, z_out_ready;
  logic [CW-1:0] z_in_ctrl;
  logic [DW-1:0] z_in_data;
  logic          z_in_ready, z_out_valid;
  logic [CW-1:0] z_out_ctrl;
  logic [DW-1:0] z_out_data;
  logic [1:0]    z_occupancy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .ZERO_DATA_ON_BUBBLE(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipe_stage_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .ZERO_DATA_ON_BUBBLE(1'b0)) dut_hold (
    .clk(clk), .reset(reset), .flush(z_flush),
    .in_valid(z_in_valid), .in_ready(z_in_ready), .in_ctrl(z_in_ctrl), .in_data(z_in_data),
    .out_valid(z_out_valid), .out_ready(z_out_ready), .out_ctrl(z_out_ctrl), .out_data(z_out_data),
    .occupancy(z_occupancy)
  );

  // Observation vector: {in_ready, out_valid, occupancy, out_ctrl, out_data}
  function automatic logic [107:0] obs();
    return {in_ready, out_valid, occupancy, out_ctrl, out_data};
  endfunction

  function automatic logic [107:0] exp_v(input logic rdy, input logic vld, input logic [1:0] occ,
                                         input logic [7:0] c, input logic [95:0] d);
    return {rdy, vld, occ, c, d};
  endfunction

  // Outputs are sampled 1 time unit after the rising edge, then inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c, input logic [95:0] d);
    in_valid = 1'b1; in_ctrl = c; in_data = d;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    z_flush = 1'b0; z_in_valid = 1'b0; z_out_ready = 1'b0; z_in_ctrl = '0; z_in_data = '0;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if (obs() !== exp_v(1'b1, 1'b0, 2'd0, 8'h00, 96'h0)) begin
      failures++; $display("FAIL reset_state got=%h exp=%h", obs(), exp_v(1'b1, 1'b0, 2'd0, 8'h00, 96'h0));
    end
  endtask

  task automatic test_single();
    // Garbage with in_valid low must be ignored.
    in_valid = 1'b0; in_ctrl = 8'hFF; in_data = 96'hDEAD; out_ready = 1'b1;
    tick();
    checks++;
    if (obs() !== exp_v(1'b1, 1'b0, 2'd0, 8'h00, 96'h0)) begin
      failures++; $display("FAIL idle_ignore got=%h exp=%h", obs(), exp_v(1'b1, 1'b0, 2'd0, 8'h00, 96'h0));
    end
    send(8'h05, 96'hA1);
    tick();
    in_valid = 1'b0;
    checks++;
    if (obs() !== exp_v(1'b1, 1'b1, 2'd1, 8'h05, 96'hA1)) begin
      failures++; $display("FAIL single_out got=%h exp=%h", obs(), exp_v(1'b1, 1'b1, 2'd1, 8'h05, 96'hA1));
    end
    tick();
    checks++;
    if (obs() !== exp_v(1'b1, 1'b0, 2'd0, 8'h00, 96'h0)) begin
      failures++; $display("FAIL single_bubble got=%h exp=%h", obs(), exp_v(1'b1, 1'b0, 2'd0, 8'h00, 96'h0));
    end
  endtask

  task automatic test_skid();
    out_ready = 1'b0;
    send(8'h11, 96'hA1);
    tick();
    checks++;
    if (obs() !== exp_v(1'b1, 1'b1, 2'd1, 8'h11, 96'hA1)) begin
      failures++; $display("FAIL skid_one got=%h exp=%h", obs(), exp_v(1'b1, 1'b1, 2'd1, 8'h11, 96'hA1));
    end
    send(8'h12, 96'hA2);
    tick();
    in_valid = 1'b0;
    checks++;
    if (obs() !== exp_v(1'b0, 1'b1, 2'd2, 8'h11, 96'hA1)) begin
      failures++; $display("FAIL skid_full got=%h exp=%h", obs(), exp_v(1'b0, 1'b1, 2'd2, 8'h11, 96'hA1));
    end
    tick();
    checks++;
    if (obs() !== exp_v(1'b0, 1'b1, 2'd2, 8'h11, 96'hA1)) begin
      failures++; $display("FAIL skid_hold got=%h exp=%h", obs(), exp_v(1'b0, 1'b1, 2'd2, 8'h11, 96'hA1));
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (obs() !== exp_v(1'b1, 1'b1, 2'd1, 8'h12, 96'hA2)) begin
      failures++; $display("FAIL skid_drain1 got=%h exp=%h", obs(), exp_v(1'b1, 1'b1, 2'd1, 8'h12, 96'hA2));
    end
    tick();
    checks++;
    if (obs() !== exp_v(1'b1, 1'b0, 2'd0, 8'h00, 96'h0)) begin
      failures++; $display("FAIL skid_drain2 got=%h exp=%h", obs(), exp_v(1'b1, 1'b0, 2'd0, 8'h00, 96'h0));
    end
  endtask

  task automatic test_stream();
    logic [7:0] c;
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      c = 8'(i + 32);
      send(c, 96'(i));
      tick();
      checks++;
      if (obs() !== exp_v(1'b1, 1'b1, 2'd1, c, 96'(i))) begin
        failures++; $display("FAIL stream_%0d got=%h exp=%h", i, obs(), exp_v(1'b1, 1'b1, 2'd1, c, 96'(i)));
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (obs() !== exp_v(1'b1, 1'b0, 2'd0, 8'h00, 96'h0)) begin
      failures++; $display("FAIL stream_end got=%h exp=%h", obs(), exp_v(1'b1, 1'b0, 2'd0, 8'h00, 96'h0));
    end
  endtask

  task automatic test_flush();
    // Flush in FULL with in_valid high.
    out_ready = 1'b0;
    send(8'h21, 96'hB1); tick();
    send(8'h22, 96'hB2); tick();
    send(8'h23, 96'hB3); flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (obs() !== exp_v(1'b1, 1'b0, 2'd0, 8'h00, 96'h0)) begin
      failures++; $display("FAIL flush_full got=%h exp=%h", obs(), exp_v(1'b1, 1'b0, 2'd0, 8'h00, 96'h0));
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        failures++; $display("FAIL flush_ghost_%0d out_valid got=%b exp=0 data=%h", i, out_valid, out_data);
      end
    end
    // Flush in ONE together with an accepted input: the input is discarded.
    out_ready = 1'b0;
    send(8'h24, 96'hB4); tick();
    send(8'h25, 96'hB5); flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (obs() !== exp_v(1'b1, 1'b0, 2'd0, 8'h00, 96'h0)) begin
      failures++; $display("FAIL flush_one got=%h exp=%h", obs(), exp_v(1'b1, 1'b0, 2'd0, 8'h00, 96'h0));
    end
  endtask

  task automatic test_reset_vs_flush();
    out_ready = 1'b0;
    send(8'h31, 96'hC8); tick();
    send(8'h32, 96'hC9); tick();
    checks++;
    if (occupancy !== 2'd2) begin
      failures++; $display("FAIL rvf_full occupancy got=%0d exp=2", occupancy);
    end
    send(8'h33, 96'hCA); reset = 1'b1; flush = 1'b1;
    tick();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (obs() !== exp_v(1'b1, 1'b0, 2'd0, 8'h00, 96'h0)) begin
      failures++; $display("FAIL rvf_reset got=%h exp=%h", obs(), exp_v(1'b1, 1'b0, 2'd0, 8'h00, 96'h0));
    end
    out_ready = 1'b1;
    send(8'h3C, 96'hC1);
    tick();
    in_valid = 1'b0;
    checks++;
    if (obs() !== exp_v(1'b1, 1'b1, 2'd1, 8'h3C, 96'hC1)) begin
      failures++; $display("FAIL rvf_c1 got=%h exp=%h", obs(), exp_v(1'b1, 1'b1, 2'd1, 8'h3C, 96'hC1));
    end
    tick();
    checks++;
    if (obs() !== exp_v(1'b1, 1'b0, 2'd0, 8'h00, 96'h0)) begin
      failures++; $display("FAIL rvf_drain got=%h exp=%h", obs(), exp_v(1'b1, 1'b0, 2'd0, 8'h00, 96'h0));
    end
  endtask

  task automatic test_hold_data();
    z_out_ready = 1'b1;
    z_in_valid = 1'b1; z_in_ctrl = 8'h4D; z_in_data = 96'hD1;
    tick();
    z_in_valid = 1'b0; z_in_data = 96'hEE;
    checks++;
    if ({z_out_valid, z_out_ctrl, z_out_data} !== {1'b1, 8'h4D, 96'hD1}) begin
      failures++; $display("FAIL hold_out got=%b/%h/%h exp=1/4d/d1", z_out_valid, z_out_ctrl, z_out_data);
    end
    tick();
    checks++;
    if ({z_out_valid, z_out_ctrl, z_out_data, z_occupancy, z_in_ready} !== {1'b0, 8'h00, 96'hD1, 2'd0, 1'b1}) begin
      failures++; $display("FAIL hold_bubble got=%b/%h/%h occ=%0d rdy=%b exp=0/00/d1 occ=0 rdy=1",
                           z_out_valid, z_out_ctrl, z_out_data, z_occupancy, z_in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_skid();
    test_stream();
    test_flush();
    test_reset_vs_flush();
    test_hold_data();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
